glb_load_scheduler: RTL

//  Sequences the DRAM->GLB preload before each layer: takes one 32-bit word stream and routes it
//  in fixed order (ifmap, weight, bias) into the three GLB SRAMs, generating write enables and

---
 rtl/glb_pkg.sv | 25 ++
 rtl/glb_phase_counter.sv | 19 +
 rtl/glb_load_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/glb_pkg.sv
// Shared types and defaults for the DRAM->GLB preload scheduler.
package glb_pkg;
    localparam int DATA_SIZE    = 32;
    localparam int IFMAP_DEPTH  = 32;
    localparam int WEIGHT_DEPTH = 1024;
    localparam int BIAS_DEPTH   = 128;
    localparam int LEN_W        = 11;
    localparam int ADDR_W       = 10;

    typedef enum logic [2:0] {IDLE, LD_IFMAP, LD_WEIGHT, LD_BIAS, DONE} load_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int depth);
        if (int'(len) > depth) return LEN_W'(depth);
        return len;
    endfunction

    // First non-empty phase after 'from'; empty phases are never occupied.
    function automatic load_state_t next_phase(input load_state_t from, input logic i_nz,
                                               input logic w_nz, input logic b_nz);
        if (from == IDLE && i_nz) return LD_IFMAP;
        if ((from == IDLE || from == LD_IFMAP) && w_nz) return LD_WEIGHT;
        if (from != LD_BIAS && from != DONE && b_nz) return LD_BIAS;
        return DONE;
    endfunction
endpackage

// File: rtl/glb_phase_counter.sv
// Word counter shared by all load phases; wraps to 0 on the terminal word.
module glb_phase_counter
    import glb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] count,
    output logic              last
);
    assign last = (LEN_W'(count) == len - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (inc)   count <= last ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/glb_load_scheduler.sv
// Routes one word stream into the ifmap, weight and bias GLBs in that order.
// Optional GLB_LOAD_CHKSUM_EN adds an XOR checksum of all transferred words.
module glb_load_scheduler #(
    parameter int DATA_SIZE    = glb_pkg::DATA_SIZE,
    parameter int IFMAP_DEPTH  = glb_pkg::IFMAP_DEPTH,
    parameter int WEIGHT_DEPTH = glb_pkg::WEIGHT_DEPTH,
    parameter int BIAS_DEPTH   = glb_pkg::BIAS_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [glb_pkg::LEN_W-1:0] cfg_ifmap_len,
    input  logic [glb_pkg::LEN_W-1:0] cfg_weight_len,
    input  logic [glb_pkg::LEN_W-1:0] cfg_bias_len,
    input  logic                      compute_busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_SIZE-1:0]      data_in,
    output logic                      ifmap_wen,
    output logic                      weight_wen,
    output logic                      bias_wen,
    output logic [9:0]                wr_addr,
    output logic [DATA_SIZE-1:0]      wr_data,
    output logic                      busy,
    output logic                      load_done
`ifdef GLB_LOAD_CHKSUM_EN
    ,
    output logic [31:0]               chksum
`endif
);
    import glb_pkg::*;

    load_state_t       state;
    logic [LEN_W-1:0]  ifmap_len, weight_len, bias_len, cur_len;
    logic [ADDR_W-1:0] count;
    logic              xfer, last, go;

    assign in_ready = (state inside {LD_IFMAP, LD_WEIGHT, LD_BIAS}) && !compute_busy;
    assign xfer     = in_valid && in_ready;
    assign go       = (state == IDLE) && start && !busy;

    always_comb begin
        cur_len = '0;
        case (state)
            LD_IFMAP:  cur_len = ifmap_len;
            LD_WEIGHT: cur_len = weight_len;
            LD_BIAS:   cur_len = bias_len;
            default:   cur_len = '0;
        endcase
    end

    glb_phase_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (xfer),
        .clr   (go),
        .len   (cur_len),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ifmap_len  <= '0;
            weight_len <= '0;
            bias_len   <= '0;
            ifmap_wen  <= 1'b0;
            weight_wen <= 1'b0;
            bias_wen   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            ifmap_wen  <= 1'b0;
            weight_wen <= 1'b0;
            bias_wen   <= 1'b0;
            case (state)
                IDLE: begin
                    load_done <= 1'b0;
                    // busy here only in the cycle carrying a post-load load_done
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        ifmap_len  <= clamp_len(cfg_ifmap_len, IFMAP_DEPTH);
                        weight_len <= clamp_len(cfg_weight_len, WEIGHT_DEPTH);
                        bias_len   <= clamp_len(cfg_bias_len, BIAS_DEPTH);
                        busy       <= 1'b1;
                        state      <= next_phase(IDLE, cfg_ifmap_len != '0,
                                                 cfg_weight_len != '0, cfg_bias_len != '0);
                        load_done  <= (cfg_ifmap_len == '0) && (cfg_weight_len == '0) &&
                                      (cfg_bias_len == '0);
                    end
                end
                LD_IFMAP, LD_WEIGHT, LD_BIAS: begin
                    if (xfer) begin
                        ifmap_wen  <= (state == LD_IFMAP);
                        weight_wen <= (state == LD_WEIGHT);
                        bias_wen   <= (state == LD_BIAS);
                        wr_addr    <= count;
                        wr_data    <= data_in;
                        if (last)
                            state <= next_phase(state, ifmap_len != '0, weight_len != '0,
                                                bias_len != '0);
                    end
                end
                DONE: begin
                    // Empty load already pulsed load_done on entry; otherwise the final
                    // write is visible now and load_done follows one cycle later.
                    state <= IDLE;
                    if (load_done) begin
                        load_done <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        load_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GLB_LOAD_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || go) chksum <= '0;
        else if (xfer) chksum <= chksum ^ data_in[31:0];
    end
`endif
endmodule
